multiplier_seq: RTL and testbench

MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

---
 rtl/mult_pkg.sv | 23 ++
 rtl/booth_enc.sv | 23 ++
 rtl/multiplier_seq.sv | 125 ++++++++++++
 tb/tb_multiplier_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// the (neg, one, two) Booth digit encoding and the iteration-count helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  // Digit value = (neg ? -1 : +1) * (one ? 1 : two ? 2 : 0).
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Operands are extended to width+2 bits, consumed two bits per iteration.
  function automatic int calc_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: maps the 3-bit multiplier window {y[2i+1], y[2i], y[2i-1]}
// to a digit in {0, +1, +2, -1, -2}.
module booth_enc
  import mult_pkg::*;
(
  input  logic [2:0]   window,
  output booth_digit_t digit
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    digit = '0;
    unique case (window)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011:         digit.two = 1'b1;
      3'b100:         begin digit.neg = 1'b1; digit.two = 1'b1; end
      3'b101, 3'b110: begin digit.neg = 1'b1; digit.one = 1'b1; end
      default:        digit = '0;
    endcase
  end

endmodule

// File: rtl/multiplier_seq.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes on both sides.
// One Booth digit per cycle; WIDTH/2+1 iterations over operands extended to WIDTH+2 bits.
module multiplier_seq
  import mult_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit DBG_EN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode_signed,
  input  logic [WIDTH-1:0]   Multiplicant,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [2:0]         dbg_digit,
  output logic [4:0]         dbg_iter
);

  localparam int EW        = WIDTH + 2;     // extended operand width
  localparam int AW        = EW + 1;        // adder / high-accumulator width (holds +/-2M)
  localparam int ACC_W     = AW + EW + 1;   // {high partial product, multiplier, prev bit}
  localparam int N         = calc_iters(WIDTH);
  localparam logic [4:0] LAST_ITER = 5'(N - 1);

  state_e              state_q,  state_d;
  logic [EW-1:0]       mcand_q,  mcand_d;
  logic [ACC_W-1:0]    acc_q,    acc_d;
  logic [4:0]          iter_q,   iter_d;
  logic [2*WIDTH-1:0]  result_q, result_d;

  logic [EW-1:0]       mcand_ext, mplier_ext;
  booth_digit_t        digit;
  logic [AW-1:0]       hi, pp_mag, pp_op, sum;
  logic [ACC_W-1:0]    shifted;

  assign mcand_ext  = {{2{mode_signed & Multiplicant[WIDTH-1]}}, Multiplicant};
  assign mplier_ext = {{2{mode_signed & Multiplier[WIDTH-1]}},   Multiplier};

  booth_enc u_booth_enc (
    .window (acc_q[2:0]),
    .digit  (digit)
  );

  // Single adder: subtraction is done as invert plus carry-in.
  assign hi = acc_q[ACC_W-1 -: AW];

  always_comb begin
    pp_mag = '0;
    if (digit.one)      pp_mag = {mcand_q[EW-1], mcand_q};
    else if (digit.two) pp_mag = {mcand_q, 1'b0};
    pp_op   = digit.neg ? ~pp_mag : pp_mag;
    sum     = hi + pp_op + AW'(digit.neg);
    shifted = {{2{sum[AW-1]}}, sum, acc_q[EW:2]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CALC;
          mcand_d = mcand_ext;
          acc_d   = {{AW{1'b0}}, mplier_ext, 1'b0};
          iter_d  = '0;
        end
      end
      ST_CALC: begin
        acc_d  = shifted;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_ITER) begin
          state_d  = ST_DONE;
          iter_d   = '0;
          result_d = shifted[2*WIDTH:1];
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

  generate
    if (DBG_EN) begin : g_dbg
      logic [2:0] digit_bits;
      assign digit_bits = digit;
      assign dbg_digit  = (state_q == ST_CALC) ? digit_bits : 3'b000;
      assign dbg_iter   = iter_q;
    end else begin : g_no_dbg
      assign dbg_digit = '0;
      assign dbg_iter  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_multiplier_seq.sv
// Scoreboard bench for multiplier_seq: the monitor pushes a reference product on each
// input transfer and pops/compares on each output transfer, checking latency and hold.
module tb_multiplier_seq;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 2 + 1;

  typedef struct {
    logic [2*WIDTH-1:0] exp;
    int                 acc_cyc;
  } sb_entry_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               mode_signed;
  logic [WIDTH-1:0]   Multiplicant;
  logic [WIDTH-1:0]   Multiplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic [2:0]         dbg_digit;
  logic [4:0]         dbg_iter;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int ready_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
  bit b2b_chk    = 1'b0;
  logic [2*WIDTH-1:0] last_result;
  int results_seen = 0;

  sb_entry_t sb[$];

  multiplier_seq #(.WIDTH(WIDTH), .DBG_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode_signed  (mode_signed),
    .Multiplicant (Multiplicant),
    .Multiplier   (Multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .dbg_digit    (dbg_digit),
    .dbg_iter     (dbg_iter)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Reference: exact integer product of the (sign- or zero-) interpreted operands.
  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic m);
    longint a, b;
    a = m ? longint'($signed(x)) : longint'(x);
    b = m ? longint'($signed(y)) : longint'(y);
    return (2*WIDTH)'(a * b);
  endfunction

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    bit prev_ov  = 1'b0;
    int last_acc = -1;
    forever begin
      @(negedge clk);
      if (!b2b_chk) last_acc = -1;
      if (rst) begin
        sb.delete();
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          sb.push_back('{exp: model(Multiplicant, Multiplier, mode_signed), acc_cyc: cyc});
          if (b2b_chk && last_acc >= 0) check("b2b_gap", 64'(cyc - last_acc), 64'(N + 2));
          last_acc = cyc;
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            fail_now("spurious_out_valid");
          end else begin
            if (!prev_ov) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(N + 1));
            check("result", 64'(result), 64'(sb[0].exp));
            check("in_ready_busy", 64'(in_ready), 64'd0);
            if (out_ready) begin
              last_result = result;
              results_seen++;
              void'(sb.pop_front());
            end
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic m);
    int n = 0;
    bit took = 1'b0;
    Multiplicant = x;
    Multiplier   = y;
    mode_signed  = m;
    in_valid     = 1'b1;
    while (!took && n < 500) begin
      @(negedge clk);
      took = in_ready;
      n++;
    end
    if (!took) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    Multiplicant = WIDTH'($urandom);
    Multiplier   = WIDTH'($urandom);
    mode_signed  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && in_ready) && n < 1000);
    if (n >= 1000) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               m;
    logic [2*WIDTH-1:0] golden;
  } dir_t;

  initial begin : main
    dir_t dir[$];
    int seen;
    dir.push_back('{16'h8000, 16'h8000, 1'b1, 32'h4000_0000});
    dir.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001});
    dir.push_back('{16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF});
    dir.push_back('{16'h8000, 16'h8000, 1'b0, 32'h4000_0000});
    dir.push_back('{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001});
    dir.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001});
    dir.push_back('{16'h0000, 16'h1234, 1'b1, 32'h0000_0000});

    rst = 1'b1; in_valid = 1'b0; mode_signed = 1'b0;
    Multiplicant = '0; Multiplier = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_dbg_digit", 64'(dbg_digit), 64'd0);
    check("rst_dbg_iter",  64'(dbg_iter),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (dir[i]) begin
      send(dir[i].x, dir[i].y, dir[i].m);
      wait_idle();
      check($sformatf("golden_%0d", i), 64'(last_result), 64'(dir[i].golden));
    end

    // Consumer stall: result and out_valid held while out_ready is low.
    ready_mode = 2;
    send(16'h7FFF, 16'h8000, 1'b1);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 100);
      if (!out_valid) fail_now("stall_out_valid_timeout");
    end
    repeat (5) @(negedge clk);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    ready_mode = 0;
    wait_idle();
    check("stall_golden", 64'(last_result), 64'hC000_8000);

    // Reset in the middle of CALC: operation is discarded.
    send(16'h1234, 16'h5678, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("dbg_iter_mid", 64'(dbg_iter), 64'd4);
    rst = 1'b1;
    #1;
    check("async_rst_in_ready",  64'(in_ready),  64'd1);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_dbg_iter",  64'(dbg_iter),  64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = results_seen;
    repeat (2 * N) @(posedge clk);
    #1;
    check("no_result_after_rst", 64'(results_seen), 64'(seen));
    send(16'd3, 16'd5, 1'b0);
    wait_idle();
    check("post_rst_3x5", 64'(last_result), 64'd15);

    // in_valid held high with operands changing every cycle.
    b2b_chk  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6 * (N + 2); i++) begin
      Multiplicant = WIDTH'($urandom);
      Multiplier   = WIDTH'($urandom);
      mode_signed  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();
    b2b_chk = 1'b0;

    // Randomised operands, both modes, with random consumer stalls.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] x, y;
      case ($urandom_range(0, 7))
        0:       x = {1'b1, {(WIDTH-1){1'b0}}};
        1:       x = '1;
        default: x = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       y = {1'b1, {(WIDTH-1){1'b0}}};
        1:       y = {1'b0, {(WIDTH-1){1'b1}}};
        default: y = WIDTH'($urandom);
      endcase
      send(x, y, 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    wait_idle();
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
